// File: rtl/sorted_frame_stats.sv
// Frame statistics for the sorter's serial output stream.
// Collects COUNT words, reports min/max/median/sum and an order flag.
module sorted_frame_stats #(
    parameter int WIDTH = 32,
    parameter int COUNT = 8,
    parameter int SUMW  = WIDTH + $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_median,
    output logic [SUMW-1:0]  out_sum,
    output logic             out_order_ok,
    output logic [7:0]       frame_cnt
);

    localparam int IW = $clog2(COUNT);
    localparam logic [IW-1:0] LAST   = IW'(COUNT - 1);
    localparam logic [IW-1:0] MED_HI = IW'(COUNT / 2);
    localparam logic [IW-1:0] MED_LO = IW'(COUNT / 2 - 1);
    localparam bit ODD = (COUNT % 2) == 1;

    typedef enum logic {
        COLLECT,
        REPORT
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0]    index;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] min_r;
    logic [SUMW-1:0]  sum_acc;
    logic [WIDTH:0]   med_acc;
    logic             order_acc;

    logic             accept;
    logic             consume;
    logic             first;
    logic             last;
    logic [SUMW-1:0]  sum_nx;
    logic [WIDTH:0]   med_nx;
    logic             order_nx;
    logic [WIDTH-1:0] med_out;

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == REPORT);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign first     = (index == '0);
    assign last      = (index == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT: if (accept && last) state_nx = REPORT;
            REPORT:  if (consume) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    // Next accumulator values; the last beat's result feeds the outputs
    // directly so a median half landing on the final word is included.
    always_comb begin
        sum_nx   = first ? SUMW'(in_data) : sum_acc + SUMW'(in_data);
        order_nx = first ? 1'b1 : (order_acc && !(in_data < prev));
        med_nx   = med_acc;
        if (ODD) begin
            if (index == MED_HI) med_nx = {1'b0, in_data};
        end else begin
            if (index == MED_LO) begin
                med_nx = {1'b0, in_data};
            end else if (index == MED_HI) begin
                med_nx = med_acc + {1'b0, in_data};
            end
        end
    end

    assign med_out = ODD ? med_nx[WIDTH-1:0] : med_nx[WIDTH:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index        <= '0;
            prev         <= '0;
            min_r        <= '0;
            sum_acc      <= '0;
            med_acc      <= '0;
            order_acc    <= 1'b1;
            out_min      <= '0;
            out_max      <= '0;
            out_median   <= '0;
            out_sum      <= '0;
            out_order_ok <= 1'b1;
            frame_cnt    <= '0;
        end else begin
            if (accept) begin
                index     <= last ? '0 : index + 1'b1;
                prev      <= in_data;
                sum_acc   <= sum_nx;
                med_acc   <= med_nx;
                order_acc <= order_nx;
                if (first) min_r <= in_data;
                if (last) begin
                    out_min      <= min_r;
                    out_max      <= in_data;
                    out_median   <= med_out;
                    out_sum      <= sum_nx;
                    out_order_ok <= order_nx;
                end
            end
            if (consume) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
